// File: rtl/ahb_decmux_param_if.sv
// ---------------------------------------------------------------------------
// ahb_decmux_param_if
//
// Purpose:
//   Bundles the single-master AHB-Lite decode/response signals that pass
//   between the bus master side and the decoder/mux block. The interface is
//   parameterised on the number of slave ports so that the per-slave vectors
//   match the decoder instance exactly.
//
// Signal summary:
//   HADDR      [31:0]            master address (address phase)
//   HTRANS     [1:0]             master transfer type
//   HSEL       [NUM_PORTS-1:0]   one-hot-or-zero slave select
//   HREADYOUTS [NUM_PORTS-1:0]   per-slave HREADYOUT
//   HRESPS     [NUM_PORTS-1:0]   per-slave HRESP
//   HRDATAS    [32*NUM_PORTS-1:0] per-slave HRDATA, port i at [32*i+31:32*i]
//   HREADY                       muxed ready to master and all slaves
//   HRESP                        muxed response to master
//   HRDATA     [31:0]            muxed read data to master
//   ERRADDR    [31:0]            captured decode-error address
//   ERRVALID                     sticky decode-error flag
//   ERRCLR                       clears ERRVALID
//
// Modports:
//   slave  - the decoder/mux block (it is the master's single AHB target)
//   master - the bus master plus the slave models that feed the responses
// ---------------------------------------------------------------------------
interface ahb_decmux_param_if #(
  parameter int NUM_PORTS = 4
);

  logic [31:0]            HADDR;
  logic [1:0]             HTRANS;
  logic [NUM_PORTS-1:0]   HSEL;
  logic [NUM_PORTS-1:0]   HREADYOUTS;
  logic [NUM_PORTS-1:0]   HRESPS;
  logic [32*NUM_PORTS-1:0] HRDATAS;
  logic                   HREADY;
  logic                   HRESP;
  logic [31:0]            HRDATA;
  logic [31:0]            ERRADDR;
  logic                   ERRVALID;
  logic                   ERRCLR;

  // Decoder/mux view: consumes the address phase and the slave responses,
  // produces the selects and the muxed response.
  modport slave (
    input  HADDR,
    input  HTRANS,
    input  HREADYOUTS,
    input  HRESPS,
    input  HRDATAS,
    input  ERRCLR,
    output HSEL,
    output HREADY,
    output HRESP,
    output HRDATA,
    output ERRADDR,
    output ERRVALID
  );

  // Master-side view: drives the address phase and the slave responses,
  // observes everything the decoder produces.
  modport master (
    output HADDR,
    output HTRANS,
    output HREADYOUTS,
    output HRESPS,
    output HRDATAS,
    output ERRCLR,
    input  HSEL,
    input  HREADY,
    input  HRESP,
    input  HRDATA,
    input  ERRADDR,
    input  ERRVALID
  );

endinterface

// File: rtl/ahb_decmux_param.sv
// ---------------------------------------------------------------------------
// ahb_decmux_param
//
// Purpose:
//   Parametrised AHB-Lite address decoder and slave response multiplexer for
//   a single-master subsystem. HADDR is decoded against a base/mask map for
//   NUM_PORTS slaves; the responses are multiplexed back to the master using
//   a data-phase select register. An integrated default slave answers
//   unmapped NONSEQ/SEQ transfers with the two-cycle ERROR response and
//   unmapped IDLE/BUSY transfers with a zero-wait OKAY.
//
// Parameters:
//   NUM_PORTS  number of slave ports, 1..16
//   BASE_ADDR  packed 32-bit base per port, port i at [32*i+31:32*i]
//   ADDR_MASK  packed 32-bit mask per port; port i hits when
//              (HADDR & mask_i) == (base_i & mask_i)
//
// Ports:
//   HCLK     in   AHB clock
//   HRESETn  in   asynchronous active-low reset
//   bus      slave modport of ahb_decmux_param_if (address phase in,
//            HSEL out, per-slave responses in, muxed response out, error
//            capture signals)
//
// Build option:
//   AHB_DECMUX_ERRCAP_EN  when defined, the address of the most recent
//   decode error is captured in ERRADDR and ERRVALID is raised until ERRCLR.
//   When undefined, ERRADDR and ERRVALID are tied to zero and ERRCLR is
//   ignored.
// ---------------------------------------------------------------------------
module ahb_decmux_param #(
  parameter int                      NUM_PORTS = 4,
  parameter logic [32*NUM_PORTS-1:0] BASE_ADDR = {NUM_PORTS{32'h0}},
  parameter logic [32*NUM_PORTS-1:0] ADDR_MASK = {NUM_PORTS{32'hFFFF_F000}}
) (
  input logic          HCLK,
  input logic          HRESETn,
  ahb_decmux_param_if.slave bus
);

  // One extra code above the last port index identifies the default slave.
  localparam int              SELW = $clog2(NUM_PORTS + 1);
  localparam logic [SELW-1:0] DEF  = SELW'(NUM_PORTS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ERR1 = 2'd1,
    ERR2 = 2'd2
  } def_state_t;

  logic [NUM_PORTS-1:0] hsel_c;
  logic                 hit;
  logic [SELW-1:0]      hit_idx;
  logic [SELW-1:0]      dsel;
  logic                 hready_c;
  logic                 hresp_c;
  logic [31:0]          hrdata_c;
  logic                 trans_active;
  logic                 err_start;
  def_state_t           def_state;
  logic                 def_ready;
  logic                 def_resp;

  // Address decode. Ports are scanned from index 0 upwards and the first
  // hit latches, so overlapping regions resolve to the lowest index and HSEL
  // can never be multi-hot. HTRANS plays no part here: the select follows
  // HADDR alone, and a miss leaves hit_idx pointing at the default slave.
  always_comb begin
    hit     = 1'b0;
    hit_idx = DEF;
    hsel_c  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!hit &&
          ((bus.HADDR & ADDR_MASK[32*i +: 32]) ==
           (BASE_ADDR[32*i +: 32] & ADDR_MASK[32*i +: 32]))) begin
        hit       = 1'b1;
        hit_idx   = SELW'(i);
        hsel_c[i] = 1'b1;
      end
    end
  end

  assign bus.HSEL = hsel_c;

  // Response multiplexer. The registered data-phase select picks one slave's
  // ready/response/data; when it points at the default slave the FSM's
  // registered ready/response are used and the read data is forced to zero.
  // Purely combinational from the slave inputs, so no wait state is added.
  always_comb begin
    hready_c = def_ready;
    hresp_c  = def_resp;
    hrdata_c = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (dsel == SELW'(i)) begin
        hready_c = bus.HREADYOUTS[i];
        hresp_c  = bus.HRESPS[i];
        hrdata_c = bus.HRDATAS[32*i +: 32];
      end
    end
  end

  assign bus.HREADY = hready_c;
  assign bus.HRESP  = hresp_c;
  assign bus.HRDATA = hrdata_c;

  // A transfer needs a real response only for NONSEQ (2'b10) and SEQ
  // (2'b11). An unmapped one accepted this cycle starts the error sequence.
  assign trans_active = (bus.HTRANS == 2'b10) || (bus.HTRANS == 2'b11);
  assign err_start    = hready_c && !hit && trans_active;

  // Data-phase select register. It only advances when the current data
  // phase completes (HREADY high); during slave wait states it holds so the
  // master keeps seeing the stalled slave even though HADDR has moved on.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel <= DEF;
    end else if (hready_c) begin
      dsel <= hit_idx;
    end
  end

  // Default-slave FSM with registered ready/response.
  //   IDLE: ready, OKAY. Unmapped IDLE/BUSY transfers finish here at once.
  //   ERR1: first ERROR cycle, ready low so the master can cancel.
  //   ERR2: second ERROR cycle, ready high. The next transfer is accepted
  //         here; if it is another unmapped NONSEQ/SEQ the sequence
  //         restarts, otherwise the FSM falls back to IDLE.
  // The outputs are loaded together with the state they belong to.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      def_state <= IDLE;
      def_ready <= 1'b1;
      def_resp  <= 1'b0;
    end else begin
      case (def_state)
        IDLE: begin
          if (err_start) begin
            def_state <= ERR1;
            def_ready <= 1'b0;
            def_resp  <= 1'b1;
          end
        end
        ERR1: begin
          def_state <= ERR2;
          def_ready <= 1'b1;
          def_resp  <= 1'b1;
        end
        ERR2: begin
          if (err_start) begin
            def_state <= ERR1;
            def_ready <= 1'b0;
            def_resp  <= 1'b1;
          end else begin
            def_state <= IDLE;
            def_ready <= 1'b1;
            def_resp  <= 1'b0;
          end
        end
        default: begin
          def_state <= IDLE;
          def_ready <= 1'b1;
          def_resp  <= 1'b0;
        end
      endcase
    end
  end

`ifdef AHB_DECMUX_ERRCAP_EN
  logic [31:0] err_addr_q;
  logic        err_valid_q;

  // Error capture. The address is taken from the address phase on the same
  // edge that moves the FSM into ERR1, so it names the offending transfer.
  // A capture on the same edge as a clear request keeps the flag set.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_addr_q  <= '0;
      err_valid_q <= 1'b0;
    end else if (err_start) begin
      err_addr_q  <= bus.HADDR;
      err_valid_q <= 1'b1;
    end else if (bus.ERRCLR) begin
      err_valid_q <= 1'b0;
    end
  end

  assign bus.ERRADDR  = err_addr_q;
  assign bus.ERRVALID = err_valid_q;
`else
  assign bus.ERRADDR  = '0;
  assign bus.ERRVALID = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_decmux_param.sv
// ---------------------------------------------------------------------------
// tb_ahb_decmux_param
//
// Purpose:
//   Self-checking bench for ahb_decmux_param with a three-port map:
//     port0 0x1000_0000 / 0xFFFF_F000
//     port1 0x1100_0000 / 0xFFFF_F000
//     port2 0x2000_0000 / 0xF000_0000
//   A second instance maps port1 onto port0's region to exercise the
//   lowest-index-wins rule. Simple slave models return programmable wait
//   states and read data. Expected data-phase responses are queued when a
//   transfer is accepted and popped by an independent monitor.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ahb_decmux_param;

  localparam int NP = 3;
  localparam logic [32*NP-1:0] MAP_BASE =
    {32'h2000_0000, 32'h1100_0000, 32'h1000_0000};
  localparam logic [32*NP-1:0] MAP_MASK =
    {32'hF000_0000, 32'hFFFF_F000, 32'hFFFF_F000};
  localparam logic [32*NP-1:0] OVL_BASE =
    {32'h2000_0000, 32'h1000_0000, 32'h1000_0000};

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

`ifdef AHB_DECMUX_ERRCAP_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  typedef struct {
    logic        resp;
    logic [31:0] data;
    int          waits;
  } exp_t;

  logic HCLK;
  logic HRESETn;

  ahb_decmux_param_if #(.NUM_PORTS(NP)) bus ();
  ahb_decmux_param_if #(.NUM_PORTS(NP)) bus2 ();

  ahb_decmux_param #(
    .NUM_PORTS (NP),
    .BASE_ADDR (MAP_BASE),
    .ADDR_MASK (MAP_MASK)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus.slave)
  );

  ahb_decmux_param #(
    .NUM_PORTS (NP),
    .BASE_ADDR (OVL_BASE),
    .ADDR_MASK (MAP_MASK)
  ) dut_ovl (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus2.slave)
  );

  int   compared   = 0;
  int   mismatched = 0;
  exp_t sbQ[$];
  int   waitCount  = 0;

  int          cfgWait [NP];
  logic [31:0] cfgData [NP];
  logic        active  [NP];
  int          cnt     [NP];
  logic [NP-1:0] s_hsel;
  logic          s_hready;
  logic [1:0]    s_htrans;

  // Free-running clock, 10 ns period.
  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Slave models sample the bus on the falling edge so the rising-edge
  // update sees settled address-phase values.
  always @(negedge HCLK) begin
    s_hsel   = bus.HSEL;
    s_hready = bus.HREADY;
    s_htrans = bus.HTRANS;
  end

  // Each slave accepts a NONSEQ/SEQ addressed to it, inserts cfgWait wait
  // states, then presents cfgData with HREADYOUT high for one cycle.
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < NP; i++) begin
        active[i] <= 1'b0;
        cnt[i]    <= 0;
      end
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (active[i] && cnt[i] != 0) cnt[i] <= cnt[i] - 1;
        else if (active[i]) active[i] <= 1'b0;
        if (s_hready && s_hsel[i] && s_htrans[1]) begin
          active[i] <= 1'b1;
          cnt[i]    <= cfgWait[i];
        end
      end
    end
  end

  // Slave outputs: a recognisable junk word when idle, so a wrong mux
  // select shows up in the read data.
  always_comb begin
    bus.HRESPS = '0;
    bus.HREADYOUTS = '1;
    bus.HRDATAS = '0;
    for (int i = 0; i < NP; i++) begin
      bus.HREADYOUTS[i] = !(active[i] && cnt[i] != 0);
      bus.HRDATAS[32*i +: 32] = active[i] ? cfgData[i] : (32'hBAD0_0000 | 32'(i));
    end
  end

  // Monitor: while a transfer is outstanding, every low-HREADY cycle is a
  // wait state (its HRESP is checked), and the high-HREADY cycle completes
  // the oldest expected response.
  always @(negedge HCLK) begin
    exp_t e;
    if (!HRESETn) begin
      waitCount = 0;
    end else if (sbQ.size() > 0) begin
      if (bus.HREADY == 1'b0) begin
        waitCount++;
        checkOutput("wait_hresp", 32'(bus.HRESP), 32'(sbQ[0].resp));
      end else begin
        e = sbQ.pop_front();
        checkOutput("dp_hresp", 32'(bus.HRESP), 32'(e.resp));
        checkOutput("dp_hrdata", bus.HRDATA, e.data);
        checkOutput("dp_waits", 32'(waitCount), 32'(e.waits));
        waitCount = 0;
      end
    end
  end

  // Drives one address phase, checks the zero-latency HSEL, waits for the
  // master to have it accepted and then queues its expected response.
  task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] trans,
                               input logic [NP-1:0] expHsel, input bit doPush,
                               input exp_t e);
    bit rdy;
    bit accepted;
    bus.HADDR  = addr;
    bus.HTRANS = trans;
    #1;
    checkOutput("hsel", 32'(bus.HSEL), 32'(expHsel));
    accepted = 1'b0;
    for (int k = 0; k < 64 && !accepted; k++) begin
      @(negedge HCLK);
      rdy = bus.HREADY;
      @(posedge HCLK);
      #1;
      if (rdy) accepted = 1'b1;
    end
    if (!accepted) begin
      mismatched++;
      $display("[TB] FAIL accept_timeout: addr 0x%08h never accepted, expected acceptance", addr);
    end else if (doPush) begin
      sbQ.push_back(e);
    end
  endtask

  // Waits (bounded) until every queued response has been seen.
  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (sbQ.size() == 0) break;
      @(posedge HCLK);
    end
    @(posedge HCLK);
    #1;
    checkOutput("drain", 32'(sbQ.size()), 32'd0);
  endtask

  initial begin
    HRESETn         = 1'b0;
    bus.HADDR       = 32'h3000_0000;
    bus.HTRANS      = T_IDLE;
    bus.ERRCLR      = 1'b0;
    bus2.HADDR      = 32'h0;
    bus2.HTRANS     = T_IDLE;
    bus2.HREADYOUTS = '1;
    bus2.HRESPS     = '0;
    bus2.HRDATAS    = '0;
    bus2.ERRCLR     = 1'b0;
    cfgWait = '{2, 5, 0};
    cfgData = '{32'h0000_1111, 32'hCAFE_F00D, 32'h2222_2222};

    repeat (2) @(posedge HCLK);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_hready", 32'(bus.HREADY), 32'd1);
    checkOutput("rst_hresp", 32'(bus.HRESP), 32'd0);
    checkOutput("rst_hrdata", bus.HRDATA, 32'd0);
    checkOutput("rst_errvalid", 32'(bus.ERRVALID), 32'd0);
    checkOutput("rst_erraddr", bus.ERRADDR, 32'd0);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    $display("[TB] port1 read with 5 wait states");
    applyStimulus(32'h1100_0004, T_NONSEQ, 3'b010, 1'b1, '{1'b0, 32'hCAFE_F00D, 5});
    cfgWait[1] = 0;

    $display("[TB] unmapped IDLE");
    applyStimulus(32'h3000_0000, T_IDLE, 3'b000, 1'b1, '{1'b0, 32'h0, 0});

    $display("[TB] pipelined port0 (2 waits) then port1");
    applyStimulus(32'h1000_0020, T_NONSEQ, 3'b001, 1'b1, '{1'b0, 32'h0000_1111, 2});
    checkOutput("idle_errvalid", 32'(bus.ERRVALID), 32'd0);
    applyStimulus(32'h1100_0008, T_NONSEQ, 3'b010, 1'b1, '{1'b0, 32'hCAFE_F00D, 0});

    $display("[TB] unmapped NONSEQ, then port2 accepted in ERR2");
    applyStimulus(32'h3000_0000, T_NONSEQ, 3'b000, 1'b1, '{1'b1, 32'h0, 1});
    applyStimulus(32'h2000_0040, T_NONSEQ, 3'b100, 1'b1, '{1'b0, 32'h2222_2222, 0});
    applyStimulus(32'h3000_0100, T_IDLE, 3'b000, 1'b0, '{1'b0, 32'h0, 0});
    drain();
    checkOutput("cap_errvalid", 32'(bus.ERRVALID), 32'(CAP));
    checkOutput("cap_erraddr", bus.ERRADDR, CAP ? 32'h3000_0000 : 32'h0);

    bus.ERRCLR = 1'b1;
    @(posedge HCLK);
    #1;
    bus.ERRCLR = 1'b0;
    checkOutput("clr_errvalid", 32'(bus.ERRVALID), 32'd0);
    checkOutput("clr_erraddr", bus.ERRADDR, CAP ? 32'h3000_0000 : 32'h0);

    $display("[TB] back-to-back unmapped NONSEQ/SEQ");
    applyStimulus(32'h4000_0000, T_NONSEQ, 3'b000, 1'b1, '{1'b1, 32'h0, 1});
    applyStimulus(32'h5000_0000, T_SEQ, 3'b000, 1'b1, '{1'b1, 32'h0, 1});
    applyStimulus(32'h6000_0000, T_IDLE, 3'b000, 1'b1, '{1'b0, 32'h0, 0});
    drain();
    checkOutput("b2b_errvalid", 32'(bus.ERRVALID), 32'(CAP));
    checkOutput("b2b_erraddr", bus.ERRADDR, CAP ? 32'h5000_0000 : 32'h0);

    $display("[TB] overlapping map");
    bus2.HADDR = 32'h1000_0010;
    #1;
    checkOutput("ovl_hsel", 32'(bus2.HSEL), 32'd1);
    bus2.HADDR = 32'h1100_0000;
    #1;
    checkOutput("ovl_miss_hsel", 32'(bus2.HSEL), 32'd0);
    bus2.HADDR = 32'h2ABC_0000;
    #1;
    checkOutput("ovl_p2_hsel", 32'(bus2.HSEL), 32'd4);

    $display("[TB] reset during ERR1");
    applyStimulus(32'h3000_0000, T_NONSEQ, 3'b000, 1'b1, '{1'b1, 32'h0, 1});
    checkOutput("err1_hready", 32'(bus.HREADY), 32'd0);
    checkOutput("err1_hresp", 32'(bus.HRESP), 32'd1);
    #1;
    HRESETn    = 1'b0;
    bus.HTRANS = T_IDLE;
    sbQ.delete();
    #1;
    checkOutput("arst_hready", 32'(bus.HREADY), 32'd1);
    checkOutput("arst_hresp", 32'(bus.HRESP), 32'd0);
    checkOutput("arst_errvalid", 32'(bus.ERRVALID), 32'd0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    @(negedge HCLK);
    checkOutput("post_rst_hready", 32'(bus.HREADY), 32'd1);
    checkOutput("post_rst_hresp", 32'(bus.HRESP), 32'd0);
    checkOutput("post_rst_erraddr", bus.ERRADDR, 32'd0);

    $display("[TB] mapped read after reset");
    @(posedge HCLK);
    #1;
    applyStimulus(32'h1000_0004, T_NONSEQ, 3'b001, 1'b1, '{1'b0, 32'h0000_1111, 2});
    applyStimulus(32'h3000_0000, T_IDLE, 3'b000, 1'b0, '{1'b0, 32'h0, 0});
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
